// File: rtl/host_buffer_writer_pkg.sv
// Definitions shared between the host buffer writer and the sequencing controller.
// Sync marker, packet layout and a byte-count helper for field sizing.
package host_buffer_writer_pkg;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
  localparam int PKT_ADDR_W = 16;
  localparam int PKT_DATA_W = 16;

  typedef struct packed {
    logic [PKT_ADDR_W-1:0] addr;
    logic [PKT_DATA_W-1:0] data;
  } buffer_packet_t;

  function automatic int bytes_for(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/host_buffer_writer_sync_fifo_fwft.sv
// Show-ahead synchronous FIFO: the head entry is presented combinationally while non-empty.
// Pops while empty and pushes while full are ignored; level is tracked separately from the pointers.
module sync_fifo_fwft #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level_q;
  logic             do_push;
  logic             do_pop;

  assign full     = (level_q == (AW+1)'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  // Head is forced to zero while empty so the outputs read zero out of reset.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/host_buffer_writer.sv
// Frames the host byte stream (SYNC, address bytes, data bytes, MSB first) into
// {address, data} packets and queues them for the sequencing controller.
module host_buffer_writer
  import host_buffer_writer_pkg::*;
#(
  parameter int          BUFFER_LENGTH = 16,
  parameter int          DATA_WIDTH    = 16,
  parameter int          FIFO_DEPTH    = 16,
  parameter logic [7:0]  SYNC_BYTE     = DEFAULT_SYNC_BYTE
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [7:0]                     rx_data,
  input  logic                           rx_valid,
  output logic                           rx_ready,
  input  logic                           buffer_read_enable,
  output logic                           buffer_empty,
  output logic [BUFFER_LENGTH-1:0]       buffer_addr,
  output logic [DATA_WIDTH-1:0]          buffer_data,
  output logic [$clog2(FIFO_DEPTH):0]    buffer_level,
  output logic                           frame_error,
  input  logic                           error_clear
);

  localparam int ADDR_BYTES = bytes_for(BUFFER_LENGTH);
  localparam int DATA_BYTES = bytes_for(DATA_WIDTH);
  localparam int MAX_BYTES  = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int CNT_W      = $clog2(MAX_BYTES + 1);
  localparam int PKT_W      = BUFFER_LENGTH + DATA_WIDTH;

  typedef enum logic [1:0] {HUNT, ADDR, DATA} state_t;

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic [BUFFER_LENGTH-1:0] addr_sr;
  logic [DATA_WIDTH-1:0]    data_sr;
  logic [DATA_WIDTH-1:0]    data_next;
  logic [BUFFER_LENGTH-1:0] addr_next;
  logic                     ready_en;
  logic                     last_addr;
  logic                     last_data;
  logic                     accept;
  logic                     push;
  logic                     fifo_full;
  logic [PKT_W-1:0]         head;

  assign last_addr = (state == ADDR) && (cnt == CNT_W'(ADDR_BYTES - 1));
  assign last_data = (state == DATA) && (cnt == CNT_W'(DATA_BYTES - 1));
  // The final data byte is held off while full; a same-cycle pop only makes room for the next cycle.
  assign rx_ready  = ready_en && !(last_data && fifo_full);
  assign accept    = rx_valid && rx_ready;
  assign push      = accept && last_data;
  assign addr_next = BUFFER_LENGTH'({addr_sr, rx_data});
  assign data_next = DATA_WIDTH'({data_sr, rx_data});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= HUNT;
      cnt         <= '0;
      addr_sr     <= '0;
      data_sr     <= '0;
      frame_error <= 1'b0;
      ready_en    <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (accept && state == HUNT && rx_data != SYNC_BYTE) frame_error <= 1'b1;
      else if (error_clear)                                 frame_error <= 1'b0;
      if (accept) begin
        case (state)
          HUNT: begin
            if (rx_data == SYNC_BYTE) begin
              state <= ADDR;
              cnt   <= '0;
            end
          end
          ADDR: begin
            addr_sr <= addr_next;
            if (last_addr) begin
              state <= DATA;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DATA: begin
            data_sr <= data_next;
            if (last_data) begin
              state <= HUNT;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  sync_fifo_fwft #(
    .WIDTH (PKT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({addr_sr, data_next}),
    .pop       (buffer_read_enable),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (buffer_empty),
    .level     (buffer_level)
  );

  assign buffer_addr = head[PKT_W-1:DATA_WIDTH];
  assign buffer_data = head[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_host_buffer_writer.sv
// Bench for host_buffer_writer: directed vector table, corner sequences and random traffic against a frame-level model.
module tb_host_buffer_writer;
  import host_buffer_writer_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        buffer_read_enable = 1'b0;
  logic        buffer_empty;
  logic [15:0] buffer_addr;
  logic [15:0] buffer_data;
  logic [4:0]  buffer_level;
  logic        frame_error;
  logic        error_clear = 1'b0;

  host_buffer_writer dut (
    .clk                (clk),
    .reset              (reset),
    .rx_data            (rx_data),
    .rx_valid           (rx_valid),
    .rx_ready           (rx_ready),
    .buffer_read_enable (buffer_read_enable),
    .buffer_empty       (buffer_empty),
    .buffer_addr        (buffer_addr),
    .buffer_data        (buffer_data),
    .buffer_level       (buffer_level),
    .frame_error        (frame_error),
    .error_clear        (error_clear)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int maxlvl  = 0;

  // Frame-level model: a queue of complete packets plus the bytes collected since the last sync.
  buffer_packet_t q[$];
  bit             m_hunt = 1'b1;
  int             m_n    = 0;
  bit             m_err  = 1'b0;
  logic [7:0]     fb[4];

  typedef struct {
    bit          v;
    logic [7:0]  b;
    bit          pop;
    bit          clr;
    bit          e_empty;
    int          e_lvl;
    logic [15:0] e_addr;
    logic [15:0] e_data;
    bit          e_err;
  } vec_t;

  vec_t vt[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_empty"}, buffer_empty, (q.size() == 0));
    check({tag, "_level"}, buffer_level, q.size());
    check({tag, "_err"}, frame_error, m_err);
    if (q.size() > 0) begin
      check({tag, "_addr"}, buffer_addr, q[0].addr);
      check({tag, "_data"}, buffer_data, q[0].data);
    end
  endtask

  // One clock: drive inputs, compare rx_ready before the edge, advance model, compare outputs after the edge.
  task automatic cycle(input bit v, input logic [7:0] b, input bit pop, input bit clr, output bit acc);
    bit exp_rdy;
    bit err_set;
    rx_valid = v; rx_data = b; buffer_read_enable = pop; error_clear = clr;
    @(negedge clk);
    exp_rdy = !(!m_hunt && m_n == 3 && q.size() == DEPTH);
    check("rx_ready", rx_ready, exp_rdy);
    acc = v && exp_rdy;
    err_set = 1'b0;
    if (pop && q.size() > 0) void'(q.pop_front());
    if (acc) begin
      if (m_hunt) begin
        if (b == 8'hA5) begin m_hunt = 1'b0; m_n = 0; end
        else err_set = 1'b1;
      end else begin
        fb[m_n] = b;
        if (m_n == 3) begin
          q.push_back('{addr: {fb[0], fb[1]}, data: {fb[2], fb[3]}});
          m_hunt = 1'b1;
          m_n = 0;
        end else begin
          m_n++;
        end
      end
    end
    if (err_set) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    @(posedge clk);
    #1;
    if (int'(buffer_level) > maxlvl) maxlvl = int'(buffer_level);
    check_model("cyc");
    rx_valid = 1'b0; buffer_read_enable = 1'b0; error_clear = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit pop);
    bit acc;
    int budget;
    budget = 0;
    acc = 1'b0;
    while (!acc && budget < 50) begin
      cycle(1'b1, b, pop, 1'b0, acc);
      budget++;
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input logic [15:0] a, input logic [15:0] d, input bit pop);
    logic [7:0] bs[5];
    bs = '{8'hA5, a[15:8], a[7:0], d[15:8], d[7:0]};
    for (int k = 0; k < 5; k++) send_byte(bs[k], pop);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit acc;
    vt[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 0, 16'h0000, 16'h0000, 1'b0};
    vt[1]  = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b1, 0, 16'h0000, 16'h0000, 1'b0};
    vt[2]  = '{1'b1, 8'h34, 1'b0, 1'b0, 1'b1, 0, 16'h0000, 16'h0000, 1'b0};
    vt[3]  = '{1'b1, 8'hBE, 1'b0, 1'b0, 1'b1, 0, 16'h0000, 16'h0000, 1'b0};
    vt[4]  = '{1'b1, 8'hEF, 1'b0, 1'b0, 1'b0, 1, 16'h1234, 16'hBEEF, 1'b0};
    vt[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 0, 16'h0000, 16'h0000, 1'b0};
    vt[6]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 0, 16'h0000, 16'h0000, 1'b1};
    vt[7]  = '{1'b1, 8'h7F, 1'b0, 1'b0, 1'b1, 0, 16'h0000, 16'h0000, 1'b1};
    vt[8]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 0, 16'h0000, 16'h0000, 1'b1};
    vt[9]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 0, 16'h0000, 16'h0000, 1'b1};
    vt[10] = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 0, 16'h0000, 16'h0000, 1'b1};
    vt[11] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 0, 16'h0000, 16'h0000, 1'b1};
    vt[12] = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1, 16'h0001, 16'h0002, 1'b1};
    vt[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1, 16'h0001, 16'h0002, 1'b0};
    vt[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 0, 16'h0000, 16'h0000, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_empty", buffer_empty, 1'b1);
    check("rst_level", buffer_level, 5'd0);
    check("rst_err", frame_error, 1'b0);
    check("rst_addr", buffer_addr, 16'h0000);
    check("rst_data", buffer_data, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ready_after_release", rx_ready, 1'b1);

    // Directed vectors: single frame, pop, discarded bytes, frame after garbage, error clear
    for (int i = 0; i < 15; i++) begin
      cycle(vt[i].v, vt[i].b, vt[i].pop, vt[i].clr, acc);
      check($sformatf("vec%0d_empty", i), buffer_empty, vt[i].e_empty);
      check($sformatf("vec%0d_level", i), buffer_level, vt[i].e_lvl);
      check($sformatf("vec%0d_err", i), frame_error, vt[i].e_err);
      if (!vt[i].e_empty) begin
        check($sformatf("vec%0d_addr", i), buffer_addr, vt[i].e_addr);
        check($sformatf("vec%0d_data", i), buffer_data, vt[i].e_data);
      end
    end

    // Sync value inside payload is plain data
    for (int k = 0; k < 5; k++) send_byte(8'hA5, 1'b0);
    check("a5_level", buffer_level, 5'd1);
    check("a5_addr", buffer_addr, 16'hA5A5);
    check("a5_data", buffer_data, 16'hA5A5);
    check("a5_err", frame_error, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, acc);

    // Continuous frames with pop held high, including pops while empty
    maxlvl = 0;
    for (int f = 0; f < 12; f++) send_frame(16'($urandom), 16'($urandom), 1'b1);
    for (int k = 0; k < 3; k++) cycle(1'b0, 8'h00, 1'b1, 1'b0, acc);
    check("cont_max_level", maxlvl, 1);
    check("cont_drained", buffer_empty, 1'b1);

    // Fill to capacity, stall the 17th frame's final byte, free one slot
    for (int f = 0; f < DEPTH; f++) send_frame(16'($urandom), 16'($urandom), 1'b0);
    check("full_level", buffer_level, 5'd16);
    send_byte(8'hA5, 1'b0);
    send_byte(8'hC3, 1'b0);
    send_byte(8'h3C, 1'b0);
    send_byte(8'h5A, 1'b0);
    cycle(1'b1, 8'h96, 1'b0, 1'b0, acc);
    check("stall_ready", rx_ready, 1'b0);
    check("stall_level", buffer_level, 5'd16);
    cycle(1'b1, 8'h96, 1'b1, 1'b0, acc);
    check("stall_pop_level", buffer_level, 5'd15);
    cycle(1'b1, 8'h96, 1'b0, 1'b0, acc);
    check("refill_level", buffer_level, 5'd16);
    while (q.size() > 0) cycle(1'b0, 8'h00, 1'b1, 1'b0, acc);
    check("full_drained", buffer_empty, 1'b1);

    // Randomised traffic
    for (int c = 0; c < 400; c++) begin
      logic [7:0] rb;
      rb = ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom);
      cycle(($urandom_range(0, 3) != 0), rb, ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 15) == 0), acc);
    end
    for (int c = 0; c < 40 && !(m_hunt && q.size() == 0); c++) begin
      if (!m_hunt) cycle(1'b1, 8'($urandom), 1'b1, 1'b0, acc);
      else         cycle(1'b0, 8'h00, 1'b1, 1'b0, acc);
    end
    check("rand_drained", buffer_empty, 1'b1);

    // Reset mid-frame with a queued packet and a raised error
    send_frame(16'h4321, 16'h8765, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h12, 1'b0);
    check("pre_rst_err", frame_error, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_empty", buffer_empty, 1'b1);
    check("mid_rst_level", buffer_level, 5'd0);
    check("mid_rst_err", frame_error, 1'b0);
    check("mid_rst_addr", buffer_addr, 16'h0000);
    check("mid_rst_data", buffer_data, 16'h0000);
    q.delete();
    m_hunt = 1'b1; m_n = 0; m_err = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_ready", rx_ready, 1'b1);
    send_frame(16'h0010, 16'h0020, 1'b0);
    check("post_rst_level", buffer_level, 5'd1);
    check("post_rst_addr", buffer_addr, 16'h0010);
    check("post_rst_data", buffer_data, 16'h0020);
    check("post_rst_err", frame_error, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/host_buffer_writer.md
Name: host_buffer_writer

Overview:
- Producer end of the host write buffer that the sequencing controller drains.
- Receives a byte stream from the host link (valid/ready) and frames it into {address, data} write packets.
- Pushes packets into a show-ahead FIFO. The controller sees buffer_empty and buffer_addr/buffer_data at the head and pops with buffer_read_enable.
- Sits between the host link byte interface and the controller/memory write ports.

Parameters:
- BUFFER_LENGTH, 16: address field width; matches the controller's buffer_addr.
- DATA_WIDTH, 16: write data width.
- FIFO_DEPTH, 16: packet entries; power of two, at least 2.
- SYNC_BYTE, 8'hA5: frame start marker.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- rx_data  in  8  host byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  byte accepted when rx_valid&rx_ready
- buffer_read_enable  in  1  pop head entry
- buffer_empty  out  1  FIFO empty
- buffer_addr  out  BUFFER_LENGTH  head entry address
- buffer_data  out  DATA_WIDTH  head entry data
- buffer_level  out  $clog2(FIFO_DEPTH)+1  entries held
- frame_error  out  1  sticky: a non-SYNC byte was discarded while hunting
- error_clear  in  1  clears frame_error

Behaviour:
- Constants:
  - ADDR_BYTES = ceil(BUFFER_LENGTH/8)
  - DATA_BYTES = ceil(DATA_WIDTH/8)
- Frame format, MSB byte first: SYNC_BYTE, then ADDR_BYTES address bytes, then DATA_BYTES data bytes.
  - Each field is assembled by shift-left-8 plus the new byte; excess upper bits are truncated.
- FSM states: HUNT, ADDR, DATA. A byte counter tracks position within the field.
  - HUNT: an accepted byte equal to SYNC_BYTE goes to ADDR with counter=0. Any other byte is discarded, frame_error<=1, and the FSM stays in HUNT.
  - ADDR: each accepted byte is shifted into addr_sr. After byte ADDR_BYTES-1 the FSM goes to DATA with counter=0.
  - DATA: each accepted byte is shifted into data_sr. The final data byte pushes {addr_sr, data_sr_shifted_with_this_byte} into the FIFO in the same cycle, and the FSM returns to HUNT.
  - A SYNC_BYTE value inside the ADDR or DATA fields is plain payload and does not resynchronise.
- rx_ready is 1 in every case except DATA on the final byte with the FIFO full. A stalled final byte stays pending until a pop frees space.
- Flow control is conservative: when full, a pop and a final-byte push in the same cycle does not occur. The pop lands first and the push follows on the next cycle.
- FIFO is show-ahead:
  - Head entry is visible combinationally from storage whenever buffer_empty=0.
  - Push at edge N gives buffer_empty=0 and valid head outputs after edge N.
  - buffer_read_enable while empty is ignored. A simultaneous push and pop when not empty and not full leaves buffer_level unchanged.
  - Read and write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. buffer_level is a separate counter, range 0..FIFO_DEPTH.
- frame_error:
  - Set on discard, clear on error_clear.
  - Set wins when both occur in the same cycle.
- Reset (asynchronous, reset=0) forces:
  - state=HUNT, counters=0, shift registers=0, pointers=0
  - buffer_level=0, buffer_empty=1, frame_error=0
  - rx_ready=1 one cycle after release
  - buffer_addr/buffer_data=0
- Reset mid-frame drops the partial frame. Reset mid-stall drops the pending byte.
- No data path latency beyond the single push cycle. Throughput is one byte per cycle while not stalled.

Decomposition:
- Package (definitions): SYNC_BYTE constant and a BufferPacket struct {addr[BUFFER_LENGTH], data[DATA_WIDTH]}, shared with the controller.
- FSM state enum {HUNT, ADDR, DATA} is local.
- One sub-module, sync_fifo_fwft: parameterised width/depth, show-ahead, with push/pop/full/empty/level. The framer FSM stays in host_buffer_writer.

Test Plan:
- Reset, then send A5 12 34 BE EF -> after the final byte's edge buffer_empty=0, buffer_addr=16'h1234, buffer_data=16'hBEEF, buffer_level=1. Pulse buffer_read_enable for 1 cycle -> buffer_empty=1.
- Send 00 7F A5 00 01 00 02 -> frame_error=1 after the first byte. Packet {0001,0002} is queued. error_clear -> frame_error=0.
- Push 16 frames with no pops -> buffer_level=16. The 17th frame's final byte sees rx_ready=0 and holds. One pop -> byte accepted next cycle, level returns to 16, FIFO order intact.
- Payload containing A5 (A5 A5 A5 A5 A5) -> one packet addr=A5A5, data=A5A5, no resync, frame_error stays 0.
- Continuous frames with buffer_read_enable asserted whenever non-empty -> all packets popped in order, level never exceeds 1, pops while empty have no effect.
- Assert reset low after A5 12 -> outputs return to reset values immediately. Next full frame A5 00 10 00 20 -> single packet {0010,0020}.
